// File: rtl/reg_bank_if.sv
// Operand register bank bus: read request/response, ALU write-back and re-init control.
interface reg_bank_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int SEL_W = $clog2(DEPTH);

  logic             rd_req;
  logic [SEL_W-1:0] rd_sel1;
  logic [SEL_W-1:0] rd_sel2;
  logic [WIDTH-1:0] op1_data;
  logic [WIDTH-1:0] op2_data;
  logic             rd_valid;
  logic             op2_load;
  logic             rd_err;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             reinit;
  logic             busy;

  modport master (
    output rd_req, rd_sel1, rd_sel2, wr_en, wr_sel, wr_data, reinit,
    input  op1_data, op2_data, rd_valid, op2_load, rd_err, busy
  );

  modport slave (
    input  rd_req, rd_sel1, rd_sel2, wr_en, wr_sel, wr_data, reinit,
    output op1_data, op2_data, rd_valid, op2_load, rd_err, busy
  );
endinterface

// File: rtl/reg_bank.sv
// 8x16 operand register bank: two registered read ports, one write-back port, sequenced
// constant-table reload. Define REG_BANK_BYPASS_EN for same-cycle write-through forwarding.
module reg_bank_entry #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             reload_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n || reload_i) q_q <= INIT_VAL;
    else if (wr_en_i)       q_q <= wr_data_i;
  end

  assign q_o = q_q;
endmodule

module reg_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_bank_if.slave   bus
);
  localparam int SEL_W = $clog2(DEPTH);

  function automatic logic [WIDTH-1:0] table_val(input int idx);
    case (idx)
      0:       table_val = WIDTH'(10);
      1:       table_val = WIDTH'(1000);
      2:       table_val = WIDTH'(100);
      3:       table_val = WIDTH'(1);
      4:       table_val = WIDTH'(10000);
      5:       table_val = WIDTH'(0);
      6:       table_val = WIDTH'(500);
      7:       table_val = WIDTH'(5000);
      default: table_val = '0;
    endcase
  endfunction

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

  state_t           state_q;
  logic [SEL_W-1:0] cnt_q;
  logic             busy_q;

  // The accept cycle of reinit already blocks reads and writes.
  logic idle_ok, wr_ok, rd_ok;
  assign idle_ok = (state_q == IDLE) && !bus.reinit;
  assign wr_ok   = idle_ok && bus.wr_en;
  assign rd_ok   = idle_ok && bus.rd_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.reinit) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          cnt_q <= cnt_q + SEL_W'(1);
          if (cnt_q == SEL_W'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            ent_we;
  logic [DEPTH-1:0]            ent_reload;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i]     = wr_ok && (bus.wr_sel == SEL_W'(i));
    assign ent_reload[i] = (state_q == INIT) && (cnt_q == SEL_W'(i));

    reg_bank_entry #(
      .WIDTH    (WIDTH),
      .INIT_VAL (table_val(i))
    ) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (ent_we[i]),
      .wr_data_i (bus.wr_data),
      .reload_i  (ent_reload[i]),
      .q_o       (regs[i])
    );
  end

  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_err_q, rd_err_d;

  // Data registers hold between reads so the Op2 latch keeps its operand.
  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    rd_vld_d = 1'b0;
    rd_err_d = 1'b0;
    if (rd_ok) begin
      if (bus.rd_sel1 != bus.rd_sel2) begin
        op1_d    = regs[bus.rd_sel1];
        op2_d    = regs[bus.rd_sel2];
        rd_vld_d = 1'b1;
`ifdef REG_BANK_BYPASS_EN
        if (wr_ok && (bus.wr_sel == bus.rd_sel1)) op1_d = bus.wr_data;
        if (wr_ok && (bus.wr_sel == bus.rd_sel2)) op2_d = bus.wr_data;
`else
        op1_d = regs[bus.rd_sel1];
`endif
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op1_q    <= '0;
      op2_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rd_vld_q <= rd_vld_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign bus.op1_data = op1_q;
  assign bus.op2_data = op2_q;
  assign bus.rd_valid = rd_vld_q;
  assign bus.op2_load = rd_vld_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_reg_bank.sv
// Directed plus randomized bench for reg_bank against a cycle-level behavioural model.
module tb_reg_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_if bus();
  reg_bank u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [15:0] TBL [8] = '{16'd10, 16'd1000, 16'd100, 16'd1,
                                      16'd10000, 16'd0, 16'd500, 16'd5000};
`ifdef REG_BANK_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'hBEEF;
`else
  localparam logic [15:0] BYP_EXP = 16'd1;
`endif

  logic [15:0] m_reg [8];
  int          m_left;
  logic [15:0] e_op1, e_op2;
  logic        e_vld, e_err, e_busy;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: remaining reload cycles tracked as a count; reads see the pre-edge array.
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = TBL[i];
      m_left = 0;
      e_op1 = 0; e_op2 = 0; e_vld = 0; e_err = 0; e_busy = 0;
    end else if (m_left > 0) begin
      m_reg[8 - m_left] = TBL[8 - m_left];
      m_left--;
      e_vld = 0; e_err = 0; e_busy = (m_left > 0);
    end else if (bus.reinit) begin
      m_left = 8;
      e_vld = 0; e_err = 0; e_busy = 1;
    end else begin
      e_vld = 0; e_err = 0; e_busy = 0;
      if (bus.rd_req) begin
        if (bus.rd_sel1 == bus.rd_sel2) e_err = 1;
        else begin
          e_vld = 1;
          e_op1 = m_reg[bus.rd_sel1];
          e_op2 = m_reg[bus.rd_sel2];
`ifdef REG_BANK_BYPASS_EN
          if (bus.wr_en && bus.wr_sel == bus.rd_sel1) e_op1 = bus.wr_data;
          if (bus.wr_en && bus.wr_sel == bus.rd_sel2) e_op2 = bus.wr_data;
`endif
        end
      end
      if (bus.wr_en) m_reg[bus.wr_sel] = bus.wr_data;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("op1_data", bus.op1_data, e_op1);
    check("op2_data", bus.op2_data, e_op2);
    check("rd_valid", 16'(bus.rd_valid), 16'(e_vld));
    check("op2_load", 16'(bus.op2_load), 16'(e_vld));
    check("rd_err",   16'(bus.rd_err),   16'(e_err));
    check("busy",     16'(bus.busy),     16'(e_busy));
  endtask

  task automatic idle_in();
    bus.rd_req = 0; bus.wr_en = 0; bus.reinit = 0;
  endtask

  task automatic rd(input int s1, input int s2);
    bus.rd_req = 1; bus.rd_sel1 = 3'(s1); bus.rd_sel2 = 3'(s2);
  endtask

  task automatic wr(input int s, input logic [15:0] d);
    bus.wr_en = 1; bus.wr_sel = 3'(s); bus.wr_data = d;
  endtask

  task automatic fill_ffff();
    for (int i = 0; i < 8; i++) begin
      idle_in(); wr(i, 16'hFFFF); step();
    end
    idle_in();
  endtask

  initial begin
    int busy_cnt;
    bus.rd_sel1 = 0; bus.rd_sel2 = 0; bus.wr_sel = 0; bus.wr_data = 0;
    idle_in();
    rst_n = 0;
    step();
    check("reset_op2", bus.op2_data, 16'h0);
    rst_n = 1;

    rd(0, 1); step();
    check("t1_op1", bus.op1_data, 16'd10);
    check("t1_op2", bus.op2_data, 16'd1000);
    check("t1_load", 16'(bus.op2_load), 16'd1);
    idle_in(); step();
    check("t1_pulse_end", 16'(bus.rd_valid), 16'd0);

    wr(6, 16'h1234); step();
    idle_in(); rd(0, 6); step();
    check("wr_then_rd", bus.op2_data, 16'h1234);

    idle_in(); wr(3, 16'hBEEF); rd(0, 3); step();
    check("same_cycle", bus.op2_data, BYP_EXP);
    idle_in(); rd(1, 3); step();
    check("write_done", bus.op2_data, 16'hBEEF);

    idle_in(); rd(4, 4); step();
    check("err_pulse", 16'(bus.rd_err), 16'd1);
    check("err_no_vld", 16'(bus.rd_valid), 16'd0);
    check("err_hold", bus.op2_data, 16'hBEEF);

    fill_ffff();
    bus.reinit = 1; step();
    idle_in();
    busy_cnt = 0;
    if (bus.busy) busy_cnt++;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin wr(0, 16'h5555); rd(0, 1); end
      bus.reinit = (k == 2);
      step();
      idle_in();
      if (bus.busy) busy_cnt++;
    end
    check("busy_len", 16'(busy_cnt), 16'd8);
    for (int p = 0; p < 4; p++) begin
      rd(2 * p, 2 * p + 1); step();
      check("reinit_tbl1", bus.op1_data, TBL[2 * p]);
      check("reinit_tbl2", bus.op2_data, TBL[2 * p + 1]);
    end
    idle_in();

    fill_ffff();
    bus.reinit = 1; step();
    idle_in(); step(); step(); step();
    rst_n = 0; step();
    check("mid_rst_busy", 16'(bus.busy), 16'd0);
    check("mid_rst_op1", bus.op1_data, 16'd0);
    rst_n = 1;
    for (int p = 0; p < 4; p++) begin
      rd(2 * p, 2 * p + 1); step();
      check("rst_tbl1", bus.op1_data, TBL[2 * p]);
      check("rst_tbl2", bus.op2_data, TBL[2 * p + 1]);
    end

    for (int n = 0; n < 400; n++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      bus.rd_req  = $urandom_range(0, 1) == 1;
      bus.rd_sel1 = 3'($urandom_range(0, 7));
      bus.rd_sel2 = 3'($urandom_range(0, 7));
      bus.wr_en   = $urandom_range(0, 9) < 4;
      bus.wr_sel  = 3'($urandom_range(0, 7));
      bus.wr_data = 16'($urandom);
      bus.reinit  = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
